// File: rtl/int_gen.sv
// int_gen: programmable interrupt generator. Raises a registered interrupt
// either when the observed CPU PC hits a trigger address or after a
// programmable number of cycles, holds it until the CPU acknowledges by
// writing to the interrupt-acknowledge address, and counts acknowledgements.
module int_gen (
  input  logic        clk,
  input  logic        reset,
  input  logic        cfg_we,
  input  logic [1:0]  cfg_addr,
  input  logic [31:0] cfg_wdata,
  output logic [31:0] cfg_rdata,
  input  logic [31:0] macroscopic_pc,
  input  logic [31:0] m_int_addr,
  input  logic [3:0]  m_int_byteen,
  output logic        interrupt,
  output logic [7:0]  int_count
);

  localparam logic [31:0] ACK_ADDR    = 32'h0000_7F20;
  localparam logic [1:0]  ADDR_CTRL   = 2'd0;
  localparam logic [1:0]  ADDR_TRIG   = 2'd1;
  localparam logic [1:0]  ADDR_PERIOD = 2'd2;
  localparam logic [1:0]  ADDR_STATUS = 2'd3;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ARMED   = 2'd1,
    ASSERT  = 2'd2,
    HOLDOFF = 2'd3
  } state_t;

  state_t      state;
  state_t      state_next;

  logic        ctrl_en;
  logic        ctrl_mode;
  logic        ctrl_rearm;
  logic [31:0] trig_pc;
  logic [31:0] period;
  logic [31:0] counter;
  logic        spur;

  logic        ack;
  logic        ctrl_wr;
  logic        trig_wr;
  logic        period_wr;
  logic        status_wr;
  logic        disable_wr;
  logic        pc_match;
  logic        counter_zero;

  logic        counter_load;
  logic        counter_dec;
  logic        en_clear;
  logic        count_inc;
  logic        spur_set;

  assign ack          = (m_int_addr == ACK_ADDR) && (m_int_byteen != 4'b0000);
  assign ctrl_wr      = cfg_we && (cfg_addr == ADDR_CTRL);
  assign trig_wr      = cfg_we && (cfg_addr == ADDR_TRIG);
  assign period_wr    = cfg_we && (cfg_addr == ADDR_PERIOD);
  assign status_wr    = cfg_we && (cfg_addr == ADDR_STATUS);
  assign disable_wr   = ctrl_wr && !cfg_wdata[0];
  assign pc_match     = (macroscopic_pc == trig_pc);
  assign counter_zero = (counter == 32'd0);

  // State register
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic; a CTRL write clearing EN overrides every other transition
  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (ctrl_wr && cfg_wdata[0]) begin
          state_next = ARMED;
        end
      end
      ARMED: begin
        if (ctrl_mode) begin
          if (counter_zero) begin
            state_next = ASSERT;
          end
        end else if (pc_match) begin
          state_next = ASSERT;
        end
      end
      ASSERT: begin
        if (ack) begin
          state_next = ctrl_rearm ? HOLDOFF : IDLE;
        end
      end
      HOLDOFF: begin
        if (ctrl_mode || !pc_match) begin
          state_next = ARMED;
        end
      end
      default: state_next = IDLE;
    endcase
    if (disable_wr) begin
      state_next = IDLE;
    end
  end

  // Control strobes and the combinational register read-back mux
  always_comb begin
    counter_load = (state_next == ARMED) && (state != ARMED);
    counter_dec  = (state == ARMED) && ctrl_mode && !counter_zero;
    count_inc    = (state == ASSERT) && ack;
    en_clear     = (state == ASSERT) && ack && !ctrl_rearm;
    spur_set     = (state != ASSERT) && ack;
    cfg_rdata    = 32'd0;
    case (cfg_addr)
      ADDR_CTRL:   cfg_rdata = {29'd0, ctrl_rearm, ctrl_mode, ctrl_en};
      ADDR_TRIG:   cfg_rdata = trig_pc;
      ADDR_PERIOD: cfg_rdata = period;
      ADDR_STATUS: cfg_rdata = {20'd0, int_count, 1'b0, spur, state};
      default:     cfg_rdata = 32'd0;
    endcase
  end

  // Config registers, down-counter, sticky spurious flag and ack counter
  always_ff @(posedge clk) begin
    if (reset) begin
      ctrl_en    <= 1'b0;
      ctrl_mode  <= 1'b0;
      ctrl_rearm <= 1'b0;
      trig_pc    <= 32'd0;
      period     <= 32'd0;
      counter    <= 32'd0;
      spur       <= 1'b0;
      int_count  <= 8'd0;
    end else begin
      if (ctrl_wr) begin
        ctrl_en    <= cfg_wdata[0];
        ctrl_mode  <= cfg_wdata[1];
        ctrl_rearm <= cfg_wdata[2];
      end
      if (en_clear) begin
        ctrl_en <= 1'b0;
      end
      if (trig_wr) begin
        trig_pc <= cfg_wdata;
      end
      if (period_wr) begin
        period <= cfg_wdata;
      end
      if (counter_load) begin
        counter <= period;
      end else if (counter_dec) begin
        counter <= counter - 32'd1;
      end
      if (spur_set) begin
        spur <= 1'b1;
      end else if (status_wr) begin
        spur <= 1'b0;
      end
      if (count_inc && (int_count != 8'hFF)) begin
        int_count <= int_count + 8'd1;
      end
    end
  end

  // Interrupt is a flop that is high exactly while the FSM sits in ASSERT
  always_ff @(posedge clk) begin
    if (reset) begin
      interrupt <= 1'b0;
    end else begin
      interrupt <= (state_next == ASSERT);
    end
  end

endmodule

// File: tb/tb_int_gen.sv
// tb_int_gen: directed scenarios plus randomized traffic for int_gen, checked
// every cycle against a behavioural model of the generator.
module tb_int_gen;

  localparam logic [31:0] ACK_ADDR  = 32'h0000_7F20;
  localparam logic [1:0]  A_CTRL    = 2'd0;
  localparam logic [1:0]  A_TRIG    = 2'd1;
  localparam logic [1:0]  A_PERIOD  = 2'd2;
  localparam logic [1:0]  A_STATUS  = 2'd3;
  localparam logic [1:0]  PH_IDLE   = 2'd0;
  localparam logic [1:0]  PH_ARMED  = 2'd1;
  localparam logic [1:0]  PH_ASSERT = 2'd2;
  localparam logic [1:0]  PH_HOLD   = 2'd3;

  typedef struct packed {
    logic [1:0]  phase;
    logic        en;
    logic        mode;
    logic        rearm;
    logic [31:0] trig;
    logic [31:0] period;
    logic [31:0] ticks;
    logic        spur;
    logic [7:0]  count;
  } model_t;

  logic        clk = 1'b0;
  logic        reset;
  logic        cfg_we;
  logic [1:0]  cfg_addr;
  logic [31:0] cfg_wdata;
  logic [31:0] cfg_rdata;
  logic [31:0] macroscopic_pc;
  logic [31:0] m_int_addr;
  logic [3:0]  m_int_byteen;
  logic        interrupt;
  logic [7:0]  int_count;

  model_t      mdl = '0;
  logic        check_on = 1'b0;
  int          check_count = 0;
  int          pass_count = 0;

  int_gen dut (
    .clk            (clk),
    .reset          (reset),
    .cfg_we         (cfg_we),
    .cfg_addr       (cfg_addr),
    .cfg_wdata      (cfg_wdata),
    .cfg_rdata      (cfg_rdata),
    .macroscopic_pc (macroscopic_pc),
    .m_int_addr     (m_int_addr),
    .m_int_byteen   (m_int_byteen),
    .interrupt      (interrupt),
    .int_count      (int_count)
  );

  always #10 clk = ~clk;

  // One clock of generator behaviour, stated rule by rule
  function automatic model_t modelStep(model_t c, logic we, logic [1:0] addr, logic [31:0] wd,
                                       logic [31:0] pc, logic [31:0] ia, logic [3:0] be);
    model_t n         = c;
    logic   is_ack    = (ia == ACK_ADDR) && (be != 4'b0000);
    logic   in_assert = (c.phase == PH_ASSERT);
    logic   pc_hit    = (pc == c.trig);
    logic   wr_ctrl   = we && (addr == A_CTRL);
    if (is_ack && !in_assert) n.spur = 1'b1;
    else if (we && addr == A_STATUS) n.spur = 1'b0;
    if (is_ack && in_assert && c.count != 8'd255) n.count = c.count + 8'd1;
    if (we && addr == A_TRIG) n.trig = wd;
    if (we && addr == A_PERIOD) n.period = wd;
    if (wr_ctrl) begin
      n.en    = wd[0];
      n.mode  = wd[1];
      n.rearm = wd[2];
    end
    case (c.phase)
      PH_IDLE: if (wr_ctrl && wd[0]) begin
        n.phase = PH_ARMED;
        n.ticks = c.period;
      end
      PH_ARMED: begin
        if (c.mode) begin
          if (c.ticks == 32'd0) n.phase = PH_ASSERT;
          else n.ticks = c.ticks - 32'd1;
        end else if (pc_hit) begin
          n.phase = PH_ASSERT;
        end
      end
      PH_ASSERT: if (is_ack) begin
        if (c.rearm) n.phase = PH_HOLD;
        else begin
          n.phase = PH_IDLE;
          n.en    = 1'b0;
        end
      end
      default: if (c.mode || !pc_hit) begin
        n.phase = PH_ARMED;
        n.ticks = c.period;
      end
    endcase
    if (wr_ctrl && !wd[0]) n.phase = PH_IDLE;
    return n;
  endfunction

  function automatic logic [31:0] modelRead(model_t c, logic [1:0] addr);
    case (addr)
      A_CTRL:   return {29'd0, c.rearm, c.mode, c.en};
      A_TRIG:   return c.trig;
      A_PERIOD: return c.period;
      default:  return {20'd0, c.count, 1'b0, c.spur, c.phase};
    endcase
  endfunction

  // Advance the model on every rising edge using the inputs the DUT sees
  always @(posedge clk) begin
    mdl <= reset ? '0 : modelStep(mdl, cfg_we, cfg_addr, cfg_wdata, macroscopic_pc,
                                  m_int_addr, m_int_byteen);
  end

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    check_count++;
    if (actual === expected) pass_count++;
    else $display("[TB] FAIL %s: got 0x%08h, required 0x%08h at %0t", name, actual, expected, $time);
  endtask

  // Compare DUT outputs against the model mid-cycle, away from the edge
  always @(negedge clk) begin
    if (check_on) begin
      checkOutput("cyc_interrupt", 32'(interrupt), 32'(mdl.phase == PH_ASSERT));
      checkOutput("cyc_int_count", 32'(int_count), 32'(mdl.count));
      checkOutput("cyc_rdata", cfg_rdata, modelRead(mdl, cfg_addr));
    end
  end

  task automatic applyStimulus(input logic we, input logic [1:0] addr, input logic [31:0] wdata,
                               input logic [31:0] pc, input logic [31:0] iaddr, input logic [3:0] be);
    cfg_we         = we;
    cfg_addr       = addr;
    cfg_wdata      = wdata;
    macroscopic_pc = pc;
    m_int_addr     = iaddr;
    m_int_byteen   = be;
    @(posedge clk);
    #1;
    cfg_we       = 1'b0;
    m_int_addr   = 32'd0;
    m_int_byteen = 4'b0000;
  endtask

  task automatic writeReg(input logic [1:0] addr, input logic [31:0] data);
    applyStimulus(1'b1, addr, data, macroscopic_pc, 32'd0, 4'b0000);
  endtask

  task automatic idlePc(input logic [31:0] pc);
    applyStimulus(1'b0, cfg_addr, 32'd0, pc, 32'd0, 4'b0000);
  endtask

  task automatic ackCycle();
    applyStimulus(1'b0, cfg_addr, 32'd0, macroscopic_pc, ACK_ADDR, 4'b0001);
  endtask

  task automatic applyReset();
    reset = 1'b1;
    idlePc(macroscopic_pc);
    reset = 1'b0;
  endtask

  task automatic checkReg(input string name, input logic [1:0] addr, input logic [31:0] expected);
    logic [31:0] d;
    cfg_addr = addr;
    #1;
    d = cfg_rdata;
    checkOutput(name, d, expected);
  endtask

  task automatic waitIrq(input logic [31:0] pc, output int cycles);
    cycles = 0;
    while (interrupt !== 1'b1 && cycles < 200) begin
      idlePc(pc);
      cycles++;
    end
    if (interrupt !== 1'b1) begin
      check_count++;
      $display("[TB] FAIL irq_timeout: interrupt=%b after %0d cycles, required 1", interrupt, cycles);
    end
  endtask

  initial begin
    int          n;
    logic        r_we;
    logic [1:0]  r_addr;
    logic [31:0] r_wd;
    logic [31:0] r_pc;
    logic [31:0] r_ia;
    logic [3:0]  r_be;
    int          k;

    reset = 1'b1;
    cfg_we = 1'b0; cfg_addr = 2'd0; cfg_wdata = 32'd0;
    macroscopic_pc = 32'd0; m_int_addr = 32'd0; m_int_byteen = 4'b0000;
    idlePc(32'd0);
    idlePc(32'd0);
    reset = 1'b0;
    check_on = 1'b1;
    $display("[TB] reset state");
    checkOutput("rst_interrupt", 32'(interrupt), 32'd0);
    checkOutput("rst_count", 32'(int_count), 32'd0);
    checkReg("rst_ctrl", A_CTRL, 32'd0);
    checkReg("rst_trig", A_TRIG, 32'd0);
    checkReg("rst_period", A_PERIOD, 32'd0);
    checkReg("rst_status", A_STATUS, 32'd0);

    $display("[TB] pc-match one-shot");
    writeReg(A_TRIG, 32'h3008);
    writeReg(A_CTRL, 32'h1);
    idlePc(32'h3000);
    checkOutput("pc_3000", 32'(interrupt), 32'd0);
    idlePc(32'h3004);
    checkOutput("pc_3004", 32'(interrupt), 32'd0);
    idlePc(32'h3008);
    checkOutput("pc_fire", 32'(interrupt), 32'd1);
    repeat (3) idlePc(32'h300C);
    checkOutput("pc_hold", 32'(interrupt), 32'd1);
    applyStimulus(1'b0, A_CTRL, 32'd0, 32'h300C, ACK_ADDR, 4'b0000);
    checkOutput("byteen0_not_ack", 32'(interrupt), 32'd1);
    applyStimulus(1'b0, A_CTRL, 32'd0, 32'h300C, 32'h7F24, 4'b1111);
    checkOutput("addr_not_ack", 32'(interrupt), 32'd1);
    ackCycle();
    checkOutput("ack_drop", 32'(interrupt), 32'd0);
    checkOutput("ack_count", 32'(int_count), 32'd1);
    checkReg("ack_ctrl_cleared", A_CTRL, 32'd0);
    checkReg("ack_status", A_STATUS, 32'h10);

    $display("[TB] periodic rearm");
    applyReset();
    writeReg(A_PERIOD, 32'd3);
    writeReg(A_CTRL, 32'h7);
    waitIrq(32'd0, n);
    checkOutput("period_first", 32'(n), 32'd4);
    for (int i = 0; i < 2; i++) begin
      ackCycle();
      waitIrq(32'd0, n);
      checkOutput("period_gap", 32'(n), 32'd5);
    end
    ackCycle();
    checkOutput("period_count", 32'(int_count), 32'd3);
    checkReg("period_holdoff", A_STATUS, 32'h33);
    writeReg(A_CTRL, 32'h0);
    checkReg("period_disabled", A_STATUS, 32'h30);

    $display("[TB] pc-match holdoff");
    applyReset();
    writeReg(A_TRIG, 32'h4000);
    writeReg(A_CTRL, 32'h5);
    idlePc(32'h4000);
    checkOutput("hold_fire", 32'(interrupt), 32'd1);
    ackCycle();
    repeat (4) idlePc(32'h4000);
    checkOutput("hold_no_refire", 32'(interrupt), 32'd0);
    checkReg("hold_state", A_STATUS, 32'h13);
    idlePc(32'h4004);
    checkReg("hold_rearmed", A_STATUS, 32'h11);
    idlePc(32'h4000);
    checkOutput("hold_refire", 32'(interrupt), 32'd1);

    $display("[TB] disable with ack, spurious ack");
    applyStimulus(1'b1, A_CTRL, 32'h0, 32'h4000, ACK_ADDR, 4'b0010);
    checkOutput("dis_ack_drop", 32'(interrupt), 32'd0);
    checkReg("dis_ack_status", A_STATUS, 32'h20);
    ackCycle();
    checkReg("spur_set", A_STATUS, 32'h24);
    writeReg(A_STATUS, 32'hFFFF_FFFF);
    checkReg("spur_clear", A_STATUS, 32'h20);
    applyStimulus(1'b1, A_STATUS, 32'd0, 32'h4000, ACK_ADDR, 4'b1000);
    checkReg("spur_wins", A_STATUS, 32'h24);
    writeReg(A_STATUS, 32'd0);

    $display("[TB] config write during assert");
    writeReg(A_PERIOD, 32'd2);
    writeReg(A_CTRL, 32'h3);
    waitIrq(32'd0, n);
    checkOutput("p2_first", 32'(n), 32'd3);
    writeReg(A_CTRL, 32'hFFFF_FFFF);
    checkOutput("wr_stay_assert", 32'(interrupt), 32'd1);
    checkReg("ctrl_upper_zero", A_CTRL, 32'h7);
    ackCycle();
    checkReg("new_rearm_used", A_STATUS, 32'h33);
    writeReg(A_CTRL, 32'h0);

    $display("[TB] count saturation");
    applyReset();
    writeReg(A_PERIOD, 32'd0);
    writeReg(A_CTRL, 32'h7);
    waitIrq(32'd0, n);
    checkOutput("p0_first", 32'(n), 32'd1);
    for (int i = 0; i < 260; i++) begin
      waitIrq(32'd0, n);
      ackCycle();
    end
    checkOutput("sat_count", 32'(int_count), 32'd255);

    $display("[TB] reset mid-assert");
    applyReset();
    writeReg(A_PERIOD, 32'd0);
    writeReg(A_CTRL, 32'h7);
    for (int i = 0; i < 5; i++) begin
      waitIrq(32'd0, n);
      ackCycle();
    end
    waitIrq(32'd0, n);
    checkOutput("pre_rst_count", 32'(int_count), 32'd5);
    reset = 1'b1;
    applyStimulus(1'b1, A_PERIOD, 32'h55, 32'd0, ACK_ADDR, 4'b0001);
    reset = 1'b0;
    checkOutput("rst_drop", 32'(interrupt), 32'd0);
    checkOutput("rst_count0", 32'(int_count), 32'd0);
    checkReg("rst2_ctrl", A_CTRL, 32'd0);
    checkReg("rst2_trig", A_TRIG, 32'd0);
    checkReg("rst2_period", A_PERIOD, 32'd0);
    checkReg("rst2_status", A_STATUS, 32'd0);

    $display("[TB] randomized traffic");
    for (int i = 0; i < 3000; i++) begin
      reset  = ($urandom_range(0, 199) == 0);
      r_we   = ($urandom_range(0, 6) == 0);
      r_addr = 2'($urandom_range(0, 3));
      case (r_addr)
        A_CTRL: begin
          r_wd = $urandom;
          if ($urandom_range(0, 3) != 0) r_wd[0] = 1'b1;
        end
        A_TRIG:   r_wd = 32'h100 + 32'(4 * $urandom_range(0, 3));
        A_PERIOD: r_wd = 32'($urandom_range(0, 6));
        default:  r_wd = $urandom;
      endcase
      r_pc = 32'h100 + 32'(4 * $urandom_range(0, 3));
      k = $urandom_range(0, 9);
      if (k < 2) begin
        r_ia = ACK_ADDR;
        r_be = 4'($urandom_range(1, 15));
      end else if (k == 2) begin
        r_ia = ACK_ADDR;
        r_be = 4'b0000;
      end else begin
        r_ia = $urandom;
        r_be = 4'($urandom_range(0, 15));
      end
      applyStimulus(r_we, r_addr, r_wd, r_pc, r_ia, r_be);
    end
    reset = 1'b0;
    idlePc(32'd0);

    $display("%0d/%0d checks passed", pass_count, check_count);
    $finish;
  end

endmodule

// File: doc/int_gen.md
INT_GEN -- requirements
Module: int_gen

Interface
REQ-001 SHALL have port clk, input, 1, sole clock; all state updates on rising edge.
REQ-002 SHALL have port reset, input, 1, synchronous active-high reset.
REQ-003 SHALL have port cfg_we, input, 1, config register write strobe.
REQ-004 SHALL have port cfg_addr, input, 2, register select: 0 CTRL, 1 TRIG_PC, 2 PERIOD, 3 STATUS.
REQ-005 SHALL have port cfg_wdata, input, 32, config write data.
REQ-006 SHALL have port cfg_rdata, output, 32, combinational read of the register selected by cfg_addr.
REQ-007 SHALL have port macroscopic_pc, input, 32, CPU macroscopic PC under observation.
REQ-008 SHALL have port m_int_addr, input, 32, CPU interrupt-acknowledge write address.
REQ-009 SHALL have port m_int_byteen, input, 4, CPU interrupt-acknowledge byte enables.
REQ-010 SHALL have port interrupt, output, 1, registered external interrupt request to the CPU.
REQ-011 SHALL have port int_count, output, 8, number of acknowledged interrupts, saturating.

Function
REQ-012 SHALL hold CTRL bits: [0] EN, [1] MODE (0 pc-match, 1 periodic), [2] REARM; bits [31:3] read 0.
REQ-013 SHALL hold TRIG_PC[31:0] and PERIOD[31:0], fully read/write.
REQ-014 SHALL read STATUS as {20'b0, int_count[7:0], 1'b0, SPUR, state[1:0]}; a write to STATUS clears SPUR only.
REQ-015 SHALL implement states IDLE=0, ARMED=1, ASSERT=2, HOLDOFF=3; interrupt=1 only in ASSERT.
REQ-016 SHALL define ack as m_int_addr == 32'h0000_7F20 AND m_int_byteen != 4'b0000 in the same cycle.
REQ-017 IDLE: when EN becomes 1 via a CTRL write, SHALL go to ARMED next cycle and load the down-counter with PERIOD.
REQ-018 ARMED, MODE=0: SHALL go to ASSERT the cycle after macroscopic_pc == TRIG_PC is sampled.
REQ-019 ARMED, MODE=1: SHALL decrement the counter each cycle and go to ASSERT the cycle after the counter is sampled at 0; first assertion is PERIOD+1 cycles after entering ARMED; PERIOD=0 fires the cycle after arming.
REQ-020 ASSERT: SHALL hold interrupt=1 indefinitely until ack; on ack SHALL increment int_count (saturating at 255) and leave ASSERT next cycle.
REQ-021 On ack with REARM=1 SHALL go to HOLDOFF; with REARM=0 SHALL go to IDLE and clear EN.
REQ-022 HOLDOFF, MODE=1: SHALL go to ARMED next cycle, reloading counter with PERIOD.
REQ-023 HOLDOFF, MODE=0: SHALL remain until macroscopic_pc != TRIG_PC is sampled, then go to ARMED, so one PC match fires once.
REQ-024 An ack sampled outside ASSERT SHALL set sticky SPUR and change no other state.
REQ-025 A CTRL write with EN=0 SHALL force IDLE next cycle from any state, dropping interrupt next cycle.
REQ-026 Simultaneous ack and EN=0 CTRL write SHALL increment int_count and go to IDLE; disable wins.
REQ-027 Simultaneous SPUR-setting ack and STATUS write SHALL leave SPUR=1.
REQ-028 CTRL/TRIG_PC/PERIOD writes other than EN=0 SHALL take effect next cycle without leaving ASSERT or reloading a running counter.
REQ-029 Config writes SHALL land on the clock edge; cfg_rdata SHALL reflect the new value the following cycle.

Reset
REQ-030 On reset SHALL set state IDLE, CTRL=0, TRIG_PC=0, PERIOD=0, counter=0, SPUR=0, int_count=0, interrupt=0.
REQ-031 Reset SHALL override any simultaneous cfg write or ack; reset during ASSERT SHALL drop interrupt the next cycle.

Verification
REQ-032 TRIG_PC=0x3008, CTRL=0x1; drive pc 0x3000,0x3004,0x3008 -> interrupt=1 the cycle after 0x3008; hold until ack to 0x7F20, byteen=4'b0001 -> interrupt=0 next cycle, int_count=1, CTRL reads 0.
REQ-033 PERIOD=3, CTRL=0x7 -> interrupt rises 4 cycles after ARMED; ack each time -> 3 assertions spaced by PERIOD+2 cycles, int_count=3.
REQ-034 CTRL=0x5, pc held at TRIG_PC across an ack -> no refire while in HOLDOFF; pc changes then returns -> second assertion.
REQ-035 Ack with state IDLE -> STATUS bit 2 (SPUR)=1, int_count unchanged; STATUS write -> SPUR=0.
REQ-036 ASSERT with CTRL write 0x0 and ack same cycle -> interrupt=0 next cycle, state IDLE, int_count incremented.
REQ-037 Reset asserted mid-ASSERT with int_count=5 -> next cycle interrupt=0, int_count=0, all registers read 0.
